// File: rtl/expr_pkg.sv
// Shared types, ASCII constants and helpers for the streaming expression evaluator.
package expr_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_REDUCE = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LPAREN = 2'd0,
    OP_ADD    = 2'd1,
    OP_SUB    = 2'd2,
    OP_MUL    = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PAREN    = 2'd1,
    ERR_SYNTAX   = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_t;

  localparam int OP_W = 2;

  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_EQ     = 8'h3D;

  // '(' binds weakest so it acts as a barrier for reductions.
  function automatic logic [1:0] prec(input op_t op);
    case (op)
      OP_MUL:         return 2'd2;
      OP_ADD, OP_SUB: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic op_t char_to_op(input logic [7:0] c);
    case (c)
      CH_MINUS:  return OP_SUB;
      CH_STAR:   return OP_MUL;
      CH_LPAREN: return OP_LPAREN;
      default:   return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/expr_stream_evaluator_lifo_stack.sv
// LIFO stack exposing the top two entries; fold replaces those two with din in one cycle.
module lifo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             fold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    top_ptr_s, sec_ptr_s;
  logic [AW-1:0]    wr_idx_s;
  logic             wr_en_s;

  assign top_ptr_s = count_q - CW'(32'd1);
  assign sec_ptr_s = count_q - CW'(32'd2);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign top       = empty ? '0 : mem_q[top_ptr_s[AW-1:0]];
  assign second    = (count_q < CW'(32'd2)) ? '0 : mem_q[sec_ptr_s[AW-1:0]];

  // Pointer update and write selection; illegal requests leave contents untouched.
  always_comb begin
    count_d  = count_q;
    wr_en_s  = 1'b0;
    wr_idx_s = top_ptr_s[AW-1:0];
    if (clear) begin
      count_d = '0;
    end else if (fold) begin
      if (count_q >= CW'(32'd2)) begin
        wr_en_s  = 1'b1;
        wr_idx_s = sec_ptr_s[AW-1:0];
        count_d  = count_q - CW'(32'd1);
      end else begin
        count_d = count_q;
      end
    end else if (push && pop) begin
      if (!empty) begin
        wr_en_s  = 1'b1;
        wr_idx_s = top_ptr_s[AW-1:0];
      end else begin
        wr_en_s = 1'b0;
      end
    end else if (push) begin
      if (!full) begin
        wr_en_s  = 1'b1;
        wr_idx_s = count_q[AW-1:0];
        count_d  = count_q + CW'(32'd1);
      end else begin
        wr_en_s = 1'b0;
      end
    end else if (pop) begin
      if (!empty) begin
        count_d = count_q - CW'(32'd1);
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/expr_stream_evaluator.sv
// Streaming infix evaluator: shunting-yard over an operator stack and a value stack,
// reducing one operator per cycle.
module expr_stream_evaluator
  import expr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             num_q, num_d;
  op_t              pend_op_q, pend_op_d;
  logic             pend_rp_q, pend_rp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  err_t             err_code_q, err_code_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             clr_s, val_push_s, val_fold_s, op_push_s, op_pop_s;
  logic [WIDTH-1:0] val_din_s, val_top_s, val_sec_s, alu_s;
  logic [CW-1:0]    val_cnt_s, op_cnt_s;
  logic             val_full_s, val_empty_s, op_full_s, op_empty_s;
  op_t              op_din_s, op_top_s, op_sec_s, in_op_s;
  logic [OP_W-1:0]  op_top_raw_s, op_sec_raw_s;
  logic             is_digit_s, need_reduce_s, fail_s;
  err_t             fail_code_s;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_val_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clr_s),
    .push   (val_push_s),
    .pop    (1'b0),
    .fold   (val_fold_s),
    .din    (val_din_s),
    .top    (val_top_s),
    .second (val_sec_s),
    .count  (val_cnt_s),
    .full   (val_full_s),
    .empty  (val_empty_s)
  );

  lifo_stack #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_op_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clr_s),
    .push   (op_push_s),
    .pop    (op_pop_s),
    .fold   (1'b0),
    .din    (op_din_s),
    .top    (op_top_raw_s),
    .second (op_sec_raw_s),
    .count  (op_cnt_s),
    .full   (op_full_s),
    .empty  (op_empty_s)
  );

  assign op_top_s      = op_t'(op_top_raw_s);
  assign op_sec_s      = op_t'(op_sec_raw_s);
  assign is_digit_s    = (in_char >= CH_0) && (in_char <= CH_9);
  assign in_op_s       = char_to_op(in_char);
  assign need_reduce_s = !op_empty_s && (prec(op_top_s) >= prec(in_op_s));

  // a op b with a = second value, b = top value.
  always_comb begin
    alu_s = '0;
    case (op_top_s)
      OP_ADD:  alu_s = val_sec_s + val_top_s;
      OP_SUB:  alu_s = val_sec_s - val_top_s;
      OP_MUL:  alu_s = val_sec_s * val_top_s;
      default: alu_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stack control; any detected fault overrides to DONE with stacks frozen.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    num_d       = num_q;
    pend_op_d   = pend_op_q;
    pend_rp_d   = pend_rp_q;
    result_d    = result_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;
    clr_s       = 1'b0;
    val_push_s  = 1'b0;
    val_fold_s  = 1'b0;
    val_din_s   = acc_q;
    op_push_s   = 1'b0;
    op_pop_s    = 1'b0;
    op_din_s    = in_op_s;
    fail_s      = 1'b0;
    fail_code_s = ERR_NONE;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_s      = 1'b1;
          acc_d      = '0;
          num_d      = 1'b0;
          result_d   = '0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = S_READ;
        end else begin
          state_d = state_q;
        end
      end
      S_READ: begin
        if (in_valid && is_digit_s) begin
          acc_d = acc_q * WIDTH'(32'd10) + WIDTH'(in_char[3:0]);
          num_d = 1'b1;
        end else if (in_valid) begin
          if (num_q) begin
            acc_d = '0;
            num_d = 1'b0;
            if (val_full_s) begin
              fail_s      = 1'b1;
              fail_code_s = ERR_OVERFLOW;
            end else begin
              val_push_s = 1'b1;
            end
          end else begin
            num_d = 1'b0;
          end
          case (in_char)
            CH_SPACE: begin
              state_d = S_READ;
            end
            CH_LPAREN: begin
              if (op_full_s) begin
                fail_s      = 1'b1;
                fail_code_s = ERR_OVERFLOW;
              end else begin
                op_push_s = 1'b1;
              end
            end
            CH_PLUS, CH_MINUS, CH_STAR: begin
              if (need_reduce_s) begin
                pend_op_d = in_op_s;
                pend_rp_d = 1'b0;
                state_d   = S_REDUCE;
              end else if (op_full_s) begin
                fail_s      = 1'b1;
                fail_code_s = ERR_OVERFLOW;
              end else begin
                op_push_s = 1'b1;
              end
            end
            CH_RPAREN: begin
              if (op_empty_s) begin
                fail_s      = 1'b1;
                fail_code_s = ERR_PAREN;
              end else if (op_top_s == OP_LPAREN) begin
                op_pop_s = 1'b1;
              end else begin
                pend_rp_d = 1'b1;
                state_d   = S_REDUCE;
              end
            end
            CH_NUL, CH_EQ: begin
              state_d = S_FINISH;
            end
            default: begin
              fail_s      = 1'b1;
              fail_code_s = ERR_SYNTAX;
            end
          endcase
        end else begin
          state_d = S_READ;
        end
      end
      S_REDUCE: begin
        if (pend_rp_q) begin
          if (op_empty_s) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_PAREN;
          end else if (op_top_s == OP_LPAREN) begin
            op_pop_s = 1'b1;
            state_d  = S_READ;
          end else if (val_cnt_s < CW'(32'd2)) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_SYNTAX;
          end else begin
            val_fold_s = 1'b1;
            val_din_s  = alu_s;
            op_pop_s   = 1'b1;
          end
        end else if (val_cnt_s < CW'(32'd2)) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_SYNTAX;
        end else begin
          val_fold_s = 1'b1;
          val_din_s  = alu_s;
          op_pop_s   = 1'b1;
          // Look one entry down so the pending operator lands in the same cycle as the last reduce.
          if (op_cnt_s >= CW'(32'd2) && prec(op_sec_s) >= prec(pend_op_q)) begin
            state_d = S_REDUCE;
          end else begin
            op_push_s = 1'b1;
            op_din_s  = pend_op_q;
            state_d   = S_READ;
          end
        end
      end
      S_FINISH: begin
        if (op_empty_s) begin
          if (!val_empty_s && val_cnt_s == CW'(32'd1)) begin
            result_d = val_top_s;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            fail_s      = 1'b1;
            fail_code_s = ERR_SYNTAX;
          end
        end else if (op_top_s == OP_LPAREN) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_PAREN;
        end else if (val_cnt_s < CW'(32'd2)) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_SYNTAX;
        end else begin
          val_fold_s = 1'b1;
          val_din_s  = alu_s;
          op_pop_s   = 1'b1;
          if (op_cnt_s == CW'(32'd1)) begin
            if (val_cnt_s == CW'(32'd2)) begin
              result_d = alu_s;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else begin
              fail_s      = 1'b1;
              fail_code_s = ERR_SYNTAX;
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fail_s) begin
      val_push_s = 1'b0;
      val_fold_s = 1'b0;
      op_push_s  = 1'b0;
      op_pop_s   = 1'b0;
      result_d   = '0;
      error_d    = 1'b1;
      err_code_d = fail_code_s;
      done_d     = 1'b1;
      state_d    = S_DONE;
    end else begin
      error_d = error_d;
    end
  end

  // Handshake/status outputs decoded from the next state so they can be registered.
  always_comb begin
    busy_d     = 1'b0;
    in_ready_d = 1'b0;
    case (state_d)
      S_READ: begin
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
      end
      S_REDUCE, S_FINISH: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      num_q      <= 1'b0;
      pend_op_q  <= OP_ADD;
      pend_rp_q  <= 1'b0;
      result_q   <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      num_q      <= num_d;
      pend_op_q  <= pend_op_d;
      pend_rp_q  <= pend_rp_d;
      result_q   <= result_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_expr_stream_evaluator.sv
// Directed bench for expr_stream_evaluator: a vector table plus reset and stack-overflow sequences.
module tb_expr_stream_evaluator;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [7:0]  in_char;

  logic        rdy16, busy16, done16, err16;
  logic [31:0] res16;
  logic [1:0]  code16;
  logic        rdy4, busy4, done4, err4;
  logic [31:0] res4;
  logic [1:0]  code4;

  bit          use4 = 1'b0;
  logic        s_rdy, s_busy, s_done, s_err;
  logic [31:0] s_res;
  logic [1:0]  s_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    string       expr;
    bit          nul;
    bit          gaps;
    logic [31:0] res;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  expr_stream_evaluator #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_char(in_char),
    .in_ready(rdy16), .busy(busy16), .done(done16), .result(res16), .error(err16),
    .err_code(code16)
  );

  expr_stream_evaluator #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_char(in_char),
    .in_ready(rdy4), .busy(busy4), .done(done4), .result(res4), .error(err4),
    .err_code(code4)
  );

  assign s_rdy  = use4 ? rdy4  : rdy16;
  assign s_busy = use4 ? busy4 : busy16;
  assign s_done = use4 ? done4 : done16;
  assign s_err  = use4 ? err4  : err16;
  assign s_res  = use4 ? res4  : res16;
  assign s_code = use4 ? code4 : code16;

  always @(negedge clk) begin
    if (s_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string e, input bit nul, input bit gaps,
                                  input logic [31:0] r, input logic er, input logic [1:0] c);
    vec_t v;
    v.expr = e; v.nul = nul; v.gaps = gaps; v.res = r; v.err = er; v.code = c;
    vt.push_back(v);
  endfunction

  task automatic run_expr(input string tag, input string s, input bit nul, input bit gaps,
                          input logic [31:0] er, input logic ee, input logic [1:0] ec,
                          output int consumed);
    byte unsigned q[$];
    int base, i, cyc, k;
    for (int j = 0; j < s.len(); j++) q.push_back(s[j]);
    if (nul) q.push_back(8'h00);
    base = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " start clears result"}, s_res, 32'd0);
    chk({tag, " start clears error"}, {31'd0, s_err}, 32'd0);
    chk({tag, " busy after start"}, {31'd0, s_busy}, 32'd1);
    i = 0; cyc = 0;
    while (i < q.size() && cyc < 500 && s_busy === 1'b1) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_char  = q[i];
        if (s_rdy === 1'b1) i++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    k = 0;
    while (done_cnt == base && k < 200) begin
      @(negedge clk); k++;
    end
    consumed = i;
    chk({tag, " done seen"}, {31'd0, done_cnt != base}, 32'd1);
    chk({tag, " result"}, s_res, er);
    chk({tag, " error"}, {31'd0, s_err}, {31'd0, ee});
    chk({tag, " err_code"}, {30'd0, s_code}, {30'd0, ec});
    repeat (3) @(negedge clk);
    chk({tag, " one done pulse"}, 32'(done_cnt - base), 32'd1);
    chk({tag, " result holds"}, s_res, er);
    chk({tag, " idle after done"}, {30'd0, s_busy, s_rdy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cons, base;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_char = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'd0, rdy16}, 32'd0);
    chk("reset busy", {31'd0, busy16}, 32'd0);
    chk("reset done", {31'd0, done16}, 32'd0);
    chk("reset result", res16, 32'd0);
    chk("reset error", {30'd0, code16, err16} , 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    add_vec("2 * 4",             1'b1, 1'b0, 32'd8,          1'b0, 2'd0);
    add_vec("2 * 3 + 5 * 4 + 3", 1'b1, 1'b0, 32'd29,         1'b0, 2'd0);
    add_vec("(12-20)*3=",        1'b0, 1'b1, 32'hFFFFFFE8,   1'b0, 2'd0);
    add_vec("(1+2",              1'b1, 1'b0, 32'd0,          1'b1, 2'd1);
    add_vec("1+*2",              1'b1, 1'b0, 32'd0,          1'b1, 2'd2);
    add_vec("10-3-2=",           1'b0, 1'b0, 32'd5,          1'b0, 2'd0);
    add_vec("7",                 1'b1, 1'b0, 32'd7,          1'b0, 2'd0);
    add_vec("2*(3+4)*5=",        1'b0, 1'b1, 32'd70,         1'b0, 2'd0);
    add_vec("1+2)",              1'b0, 1'b0, 32'd0,          1'b1, 2'd1);
    add_vec("3#4=",              1'b0, 1'b0, 32'd0,          1'b1, 2'd2);
    add_vec("65536*65536=",      1'b0, 1'b0, 32'd0,          1'b0, 2'd0);
    add_vec("0-1=",              1'b0, 1'b0, 32'hFFFFFFFF,   1'b0, 2'd0);
    add_vec("4294967297=",       1'b0, 1'b0, 32'd1,          1'b0, 2'd0);
    add_vec(" 12 + 3 =",         1'b0, 1'b0, 32'd15,         1'b0, 2'd0);
    add_vec("1 2=",              1'b0, 1'b0, 32'd0,          1'b1, 2'd2);

    for (int v = 0; v < vt.size(); v++) begin
      run_expr($sformatf("v%0d", v), vt[v].expr, vt[v].nul, vt[v].gaps,
               vt[v].res, vt[v].err, vt[v].code, cons);
    end

    // Error stops consumption: "3#4=" must stop right after '#'.
    run_expr("drop", "3#4=", 1'b0, 1'b0, 32'd0, 1'b1, 2'd2, cons);
    chk("drop consumed", 32'(cons), 32'd2);

    // Reset in the middle of "9*9" abandons it silently.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    base = done_cnt;
    in_valid = 1'b1; in_char = 8'h39;
    @(negedge clk); in_char = 8'h2A;
    @(negedge clk); in_char = 8'h39;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midreset busy", {31'd0, busy16}, 32'd0);
    chk("midreset in_ready", {31'd0, rdy16}, 32'd0);
    chk("midreset done", {31'd0, done16}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midreset no done", 32'(done_cnt - base), 32'd0);
    run_expr("after_reset", "7-2=", 1'b0, 1'b0, 32'd5, 1'b0, 2'd0, cons);

    // DEPTH=4 instance: the fifth '(' overflows the operator stack.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    use4 = 1'b1;
    @(negedge clk);
    run_expr("ovf", "((((((1))))))", 1'b1, 1'b0, 32'd0, 1'b1, 2'd3, cons);
    chk("ovf consumed", 32'(cons), 32'd5);
    use4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
